// File: rtl/fu_wb_arbiter_if.sv
// -----------------------------------------------------------------------------
// fu_wb_arbiter_pkg / squash_if
//
// Purpose:
//   Shared types for the FU writeback arbiter.
//   - fu_output_t is the result record every functional unit produces.
//   - squash_if carries the pipeline-wide flush request.
//
// Contents:
//   fu_wb_arbiter_pkg  package with the fu_output_t result record
//                      (pc, id, prd, rdval)
//   squash_if          interface with a single 'valid' flush strobe
//                        master modport drives valid
//                        slave modport samples valid
// -----------------------------------------------------------------------------
package fu_wb_arbiter_pkg;

   // One FU result:
   //   pc    - program counter of the producing instruction
   //   id    - instruction tag
   //   prd   - physical destination register
   //   rdval - value to be written to prd
   typedef struct packed {
      logic [31:0] pc;
      logic [7:0]  id;
      logic [5:0]  prd;
      logic [31:0] rdval;
   } fu_output_t;

endpackage

interface squash_if;
   logic valid;

   modport master (output valid);
   modport slave  (input  valid);
endinterface

// File: rtl/fu_wb_arbiter.sv
// -----------------------------------------------------------------------------
// fu_wb_arbiter
//
// Purpose:
//   Collects results from NFU functional units. FUs cannot be stalled, so each
//   FU owns a small FIFO that absorbs its results. The buffered results are
//   round-robin arbitrated onto NWB register-file writeback ports.
//   A per-FU almost-full flag lets issue stop dispatching to an FU before its
//   FIFO can overflow.
//
// Parameters:
//   NFU    number of FU result inputs
//   NWB    number of writeback ports (NWB <= NFU)
//   DEPTH  entries per FU FIFO (power of 2, >= 2)
//   SLACK  free entries reserved for results already in flight;
//          almost-full asserts at occupancy >= DEPTH-SLACK
//
// Ports:
//   clk               clock
//   rst               synchronous reset, active-high
//   fuoutput_i[NFU]   per-FU result payload
//   fuoutput_i_valid  per-FU result valid
//   fu_afull_o        per-FU almost-full (issue must not dispatch to FU i)
//   wb_o[NWB]         writeback port payload
//   wb_o_valid        writeback port valid (RF write enable)
//   overflow_o        sticky: a result arrived at a full FIFO and was lost
//   squash_io         flush strobe; drops all buffered and incoming results
//
// Configuration:
//   WB_BYPASS_EN  When defined, an FU whose FIFO is empty may win a grant with
//                 its incoming result. That result is written back in the same
//                 cycle instead of being stored. When undefined, every result
//                 passes through the FIFO (minimum latency one cycle).
// -----------------------------------------------------------------------------
module fu_wb_arbiter
   import fu_wb_arbiter_pkg::*;
#(
   parameter int NFU   = 4,
   parameter int NWB   = 2,
   parameter int DEPTH = 4,
   parameter int SLACK = 2
) (
   input  logic             clk,
   input  logic             rst,
   input  fu_output_t       fuoutput_i [NFU],
   input  logic [NFU-1:0]   fuoutput_i_valid,
   output logic [NFU-1:0]   fu_afull_o,
   output fu_output_t       wb_o [NWB],
   output logic [NWB-1:0]   wb_o_valid,
   output logic             overflow_o,
   squash_if.slave          squash_io
);

   localparam int AW  = $clog2(DEPTH);
   localparam int CW  = AW + 1;
   localparam int FW  = (NFU > 1) ? $clog2(NFU) : 1;
   localparam int FW1 = FW + 1;
   localparam int WW  = (NWB > 1) ? $clog2(NWB) : 1;
   localparam int GW  = $clog2(NWB + 1);

   localparam logic [CW-1:0]  FULL_C  = CW'(DEPTH);
   localparam logic [CW-1:0]  AFULL_C = CW'(DEPTH - SLACK);
   localparam logic [FW1-1:0] NFU_C   = FW1'(NFU);
   localparam logic [GW-1:0]  NWB_C   = GW'(NWB);
   localparam logic [FW-1:0]  LAST_FU = FW'(NFU - 1);

   fu_output_t     mem_q   [NFU][DEPTH];
   logic [AW-1:0]  head_q  [NFU];
   logic [AW-1:0]  tail_q  [NFU];
   logic [CW-1:0]  count_q [NFU];
   logic [FW-1:0]  rr_q;
   logic           overflow_q;

   logic [NFU-1:0] nonempty;
   logic [NFU-1:0] req;
   logic [NFU-1:0] pop;
   logic [NFU-1:0] bypass;
   logic [NFU-1:0] push;
   logic [NFU-1:0] drop_ovf;
   logic [FW-1:0]  rr_d;
   logic           flush;

   // Reset and squash both suppress every grant and every push in the
   // current cycle. Nothing reaches the register file while the machine is
   // being flushed.
   assign flush = rst | squash_io.valid;

   // Per-FU requests.
   // A FIFO holding data always requests. With bypass built in, an empty
   // FIFO whose FU is presenting a result also requests, so that result can
   // go straight to a writeback port.
   always_comb begin
      nonempty = '0;
      req      = '0;
      for (int i = 0; i < NFU; i++) begin
         nonempty[i] = (count_q[i] != '0);
`ifdef WB_BYPASS_EN
         req[i] = !flush && (nonempty[i] || fuoutput_i_valid[i]);
`else
         req[i] = !flush && nonempty[i];
`endif
      end
   end

   // Round-robin grant.
   // - Walk the FUs starting at rr_q, wrapping modulo NFU.
   // - The k-th requester found drives writeback port k, until NWB ports are
   //   used up.
   // - A granted non-empty FIFO pops its head. A granted empty FIFO can only
   //   come from bypass, so the live input is forwarded instead.
   // - The pointer moves to just past the last granted FU, so that FU has
   //   the lowest priority next cycle.
   always_comb begin
      logic [FW1-1:0] scan;
      logic [FW-1:0]  idx;
      logic [GW-1:0]  n_grant;

      pop        = '0;
      bypass     = '0;
      wb_o_valid = '0;
      for (int k = 0; k < NWB; k++) begin
         wb_o[k] = '0;
      end
      rr_d    = rr_q;
      n_grant = '0;
      scan    = '0;
      idx     = '0;

      for (int j = 0; j < NFU; j++) begin
         scan = {1'b0, rr_q} + FW1'(j);
         if (scan >= NFU_C) begin
            scan = scan - NFU_C;
         end
         idx = scan[FW-1:0];

         if (req[idx] && (n_grant < NWB_C)) begin
            wb_o_valid[n_grant[WW-1:0]] = 1'b1;
            if (nonempty[idx]) begin
               wb_o[n_grant[WW-1:0]] = mem_q[idx][head_q[idx]];
               pop[idx]              = 1'b1;
            end else begin
               wb_o[n_grant[WW-1:0]] = fuoutput_i[idx];
               bypass[idx]           = 1'b1;
            end
            n_grant = n_grant + GW'(1);
            rr_d    = (idx == LAST_FU) ? '0 : idx + FW'(1);
         end
      end
   end

   // Push and overflow decisions.
   // - A full FIFO can still accept a push when it pops in the same cycle.
   //   The write lands in the slot being vacated.
   // - A push into a full FIFO that does not pop is dropped and flagged.
   // - Results that are bypassed never enter the FIFO.
   // - Results that arrive during a flush are discarded silently.
   always_comb begin
      push     = '0;
      drop_ovf = '0;
      for (int i = 0; i < NFU; i++) begin
         if (fuoutput_i_valid[i] && !flush && !bypass[i]) begin
            if ((count_q[i] != FULL_C) || pop[i]) begin
               push[i] = 1'b1;
            end else begin
               drop_ovf[i] = 1'b1;
            end
         end
      end
   end

   // Almost-full comes straight from registered occupancy.
   // This keeps the flag free of any combinational path from the FU inputs
   // back into issue.
   always_comb begin
      fu_afull_o = '0;
      for (int i = 0; i < NFU; i++) begin
         fu_afull_o[i] = (count_q[i] >= AFULL_C);
      end
   end

   assign overflow_o = overflow_q;

   // FIFO bookkeeping, round-robin pointer and the sticky overflow flag.
   // - Reset clears everything.
   // - Squash empties every FIFO but keeps the arbitration position and any
   //   overflow already recorded. That way a flush does not hide an earlier
   //   design error.
   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < NFU; i++) begin
            head_q[i]  <= '0;
            tail_q[i]  <= '0;
            count_q[i] <= '0;
         end
         rr_q       <= '0;
         overflow_q <= 1'b0;
      end else if (squash_io.valid) begin
         for (int i = 0; i < NFU; i++) begin
            head_q[i]  <= '0;
            tail_q[i]  <= '0;
            count_q[i] <= '0;
         end
      end else begin
         for (int i = 0; i < NFU; i++) begin
            if (push[i]) begin
               tail_q[i] <= tail_q[i] + AW'(1);
            end
            if (pop[i]) begin
               head_q[i] <= head_q[i] + AW'(1);
            end
            if (push[i] && !pop[i]) begin
               count_q[i] <= count_q[i] + CW'(1);
            end else if (!push[i] && pop[i]) begin
               count_q[i] <= count_q[i] - CW'(1);
            end
         end
         rr_q <= rr_d;
         if (|drop_ovf) begin
            overflow_q <= 1'b1;
         end
      end
   end

   // FIFO storage.
   // The array has no reset: an entry is only ever read after it has been
   // written, because occupancy is tracked by count_q.
   always_ff @(posedge clk) begin
      for (int i = 0; i < NFU; i++) begin
         if (push[i]) begin
            mem_q[i][tail_q[i]] <= fuoutput_i[i];
         end
      end
   end

endmodule

// File: tb/tb_fu_wb_arbiter.sv
// -----------------------------------------------------------------------------
// tb_fu_wb_arbiter
//
// Purpose:
//   Self-checking bench for fu_wb_arbiter with NFU=4, NWB=2, DEPTH=4, SLACK=2.
//
//   - A table of per-cycle records gives, for each cycle:
//       inputs:   reset, squash, per-FU valid, pushes expected to be lost
//       expected: writeback valids, the FU expected on each writeback port,
//                 almost-full flags, overflow flag
//   - Payloads are checked through a scoreboard. Every result that should
//     survive is queued when it is driven, and dequeued when its FU shows up
//     on a writeback port.
//   - A short hand-written sequence checks writeback latency for a lone FU3
//     result, with and without WB_BYPASS_EN.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_fu_wb_arbiter;
   import fu_wb_arbiter_pkg::*;

   localparam int NFU   = 4;
   localparam int NWB   = 2;
   localparam int NROWS = 37;

   logic             clk = 1'b0;
   logic             rst;
   fu_output_t       fu_in [NFU];
   logic [NFU-1:0]   fu_vld;
   logic [NFU-1:0]   afull;
   fu_output_t       wb [NWB];
   logic [NWB-1:0]   wb_vld;
   logic             ovf;

   squash_if sq_if ();

   fu_wb_arbiter #(
      .NFU   (NFU),
      .NWB   (NWB),
      .DEPTH (4),
      .SLACK (2)
   ) dut (
      .clk              (clk),
      .rst              (rst),
      .fuoutput_i       (fu_in),
      .fuoutput_i_valid (fu_vld),
      .fu_afull_o       (afull),
      .wb_o             (wb),
      .wb_o_valid       (wb_vld),
      .overflow_o       (ovf),
      .squash_io        (sq_if)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic       rst;
      logic       sq;
      logic [3:0] vld;
      logic [3:0] drop;
      logic [1:0] ewv;
      int         ef0;
      int         ef1;
      logic [3:0] eaf;
      logic       eovf;
   } vec_t;

   typedef struct {
      int         fu;
      fu_output_t p;
   } sb_t;

   vec_t tbl [NROWS];
   sb_t  sbq [$];
   int   n_cmp = 0;
   int   n_err = 0;

   // Unique, recognisable payload for FU i driven in table row r.
   // Row 1 / FU0 carries prd=5, rdval=0xAB.
   function automatic fu_output_t mkPayload(input int r, input int i);
      fu_output_t p;
      p.pc    = 32'h1000_0000 + 32'(r * 256 + i * 4);
      p.id    = 8'(i);
      p.prd   = 6'((r * 4 + i) % 64);
      p.rdval = 32'hA500_0000 + 32'(r * 16 + i);
      if (r == 1 && i == 0) begin
         p.prd   = 6'd5;
         p.rdval = 32'h0000_00AB;
      end
      return p;
   endfunction

   function automatic vec_t mkv(input logic rs, input logic sq,
                                input logic [3:0] v, input logic [3:0] d,
                                input logic [1:0] ewv, input int f0,
                                input int f1, input logic [3:0] af,
                                input logic ov);
      vec_t t;
      t.rst  = rs;
      t.sq   = sq;
      t.vld  = v;
      t.drop = d;
      t.ewv  = ewv;
      t.ef0  = f0;
      t.ef1  = f1;
      t.eaf  = af;
      t.eovf = ov;
      return t;
   endfunction

   task automatic cmp(input string name, input int r,
                      input logic [127:0] act, input logic [127:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("[TB] FAIL %s row %0d: got %h expected %h", name, r, act, exp);
      end
   endtask

   // Take the oldest queued result for this FU and compare it to the
   // writeback payload.
   task automatic sbPop(input int fu, input fu_output_t act, input int r);
      int hit;
      hit = -1;
      for (int n = 0; n < sbq.size(); n++) begin
         if (hit < 0 && sbq[n].fu == fu) begin
            hit = n;
         end
      end
      if (hit < 0) begin
         n_cmp++;
         n_err++;
         $display("[TB] FAIL sb_empty row %0d: got writeback for FU%0d, expected no pending result", r, fu);
      end else begin
         cmp("wb_payload", r, 128'(act), 128'(sbq[hit].p));
         sbq.delete(hit);
      end
   endtask

   task automatic applyStimulus(input vec_t v, input int r);
      rst          = v.rst;
      sq_if.valid  = v.sq;
      fu_vld       = v.vld;
      for (int i = 0; i < NFU; i++) begin
         fu_in[i] = mkPayload(r, i);
      end
   endtask

   task automatic checkOutput(input vec_t v, input int r);
      cmp("wb_valid", r, 128'(wb_vld), 128'(v.ewv));
      cmp("afull",    r, 128'(afull),  128'(v.eaf));
      cmp("overflow", r, 128'(ovf),    128'(v.eovf));
      if (v.ewv[0] && wb_vld[0]) begin
         sbPop(v.ef0, wb[0], r);
      end
      if (v.ewv[1] && wb_vld[1]) begin
         sbPop(v.ef1, wb[1], r);
      end
   endtask

   task automatic sbUpdate(input vec_t v, input int r);
      if (v.rst || v.sq) begin
         sbq.delete();
      end else begin
         for (int i = 0; i < NFU; i++) begin
            if (v.vld[i] && !v.drop[i]) begin
               sbq.push_back('{fu: i, p: mkPayload(r, i)});
            end
         end
      end
   endtask

   initial begin
      #200000;
      $display("[TB] FAIL timeout: simulation did not finish in time");
      $fatal(1, "[TB] timeout");
   end

   initial begin
      fu_output_t p;

      rst         = 1'b1;
      sq_if.valid = 1'b0;
      fu_vld      = '0;
      for (int i = 0; i < NFU; i++) begin
         fu_in[i] = '0;
      end

      //              rst sq  vld      drop     ewv   f0 f1 afull    ovf
      tbl[0]  = mkv(0, 0, 4'b0000, 4'b0000, 2'b00, 0, 0, 4'b0000, 0);
      tbl[1]  = mkv(0, 0, 4'b0001, 4'b0000, 2'b00, 0, 0, 4'b0000, 0);
      tbl[2]  = mkv(0, 0, 4'b0000, 4'b0000, 2'b01, 0, 0, 4'b0000, 0);
      tbl[3]  = mkv(1, 0, 4'b0000, 4'b0000, 2'b00, 0, 0, 4'b0000, 0);
      tbl[4]  = mkv(0, 0, 4'b1111, 4'b0000, 2'b00, 0, 0, 4'b0000, 0);
      tbl[5]  = mkv(0, 0, 4'b0000, 4'b0000, 2'b11, 0, 1, 4'b0000, 0);
      tbl[6]  = mkv(0, 0, 4'b0000, 4'b0000, 2'b11, 2, 3, 4'b0000, 0);
      tbl[7]  = mkv(0, 0, 4'b0000, 4'b0000, 2'b00, 0, 0, 4'b0000, 0);
      tbl[8]  = mkv(0, 0, 4'b0100, 4'b0000, 2'b00, 0, 0, 4'b0000, 0);
      tbl[9]  = mkv(0, 0, 4'b0100, 4'b0000, 2'b01, 2, 0, 4'b0000, 0);
      tbl[10] = mkv(0, 0, 4'b0100, 4'b0000, 2'b01, 2, 0, 4'b0000, 0);
      tbl[11] = mkv(0, 0, 4'b0000, 4'b0000, 2'b01, 2, 0, 4'b0000, 0);
      tbl[12] = mkv(0, 0, 4'b1001, 4'b0000, 2'b00, 0, 0, 4'b0000, 0);
      tbl[13] = mkv(0, 0, 4'b0000, 4'b0000, 2'b11, 3, 0, 4'b0000, 0);
      tbl[14] = mkv(0, 0, 4'b1111, 4'b0000, 2'b00, 0, 0, 4'b0000, 0);
      tbl[15] = mkv(0, 0, 4'b1111, 4'b0000, 2'b11, 1, 2, 4'b0000, 0);
      tbl[16] = mkv(0, 0, 4'b1111, 4'b0000, 2'b11, 3, 0, 4'b1001, 0);
      tbl[17] = mkv(0, 0, 4'b1111, 4'b0000, 2'b11, 1, 2, 4'b1111, 0);
      tbl[18] = mkv(0, 0, 4'b1111, 4'b0000, 2'b11, 3, 0, 4'b1111, 0);
      tbl[19] = mkv(0, 0, 4'b1111, 4'b0000, 2'b11, 1, 2, 4'b1111, 0);
      tbl[20] = mkv(0, 0, 4'b1111, 4'b0000, 2'b11, 3, 0, 4'b1111, 0);
      tbl[21] = mkv(0, 0, 4'b1111, 4'b1001, 2'b11, 1, 2, 4'b1111, 0);
      tbl[22] = mkv(0, 0, 4'b0000, 4'b0000, 2'b11, 3, 0, 4'b1111, 1);
      tbl[23] = mkv(0, 1, 4'b0001, 4'b0001, 2'b00, 0, 0, 4'b1111, 1);
      tbl[24] = mkv(0, 0, 4'b0000, 4'b0000, 2'b00, 0, 0, 4'b0000, 1);
      tbl[25] = mkv(1, 0, 4'b0000, 4'b0000, 2'b00, 0, 0, 4'b0000, 1);
      tbl[26] = mkv(0, 0, 4'b0000, 4'b0000, 2'b00, 0, 0, 4'b0000, 0);
      tbl[27] = mkv(0, 0, 4'b0001, 4'b0000, 2'b00, 0, 0, 4'b0000, 0);
      tbl[28] = mkv(0, 0, 4'b0000, 4'b0000, 2'b01, 0, 0, 4'b0000, 0);
      tbl[29] = mkv(0, 0, 4'b1110, 4'b0000, 2'b00, 0, 0, 4'b0000, 0);
      tbl[30] = mkv(0, 1, 4'b0001, 4'b0001, 2'b00, 0, 0, 4'b0000, 0);
      tbl[31] = mkv(0, 0, 4'b0000, 4'b0000, 2'b00, 0, 0, 4'b0000, 0);
      tbl[32] = mkv(0, 0, 4'b0101, 4'b0000, 2'b00, 0, 0, 4'b0000, 0);
      tbl[33] = mkv(0, 0, 4'b0000, 4'b0000, 2'b11, 2, 0, 4'b0000, 0);
      tbl[34] = mkv(0, 0, 4'b0110, 4'b0000, 2'b00, 0, 0, 4'b0000, 0);
      tbl[35] = mkv(1, 0, 4'b0000, 4'b0000, 2'b00, 0, 0, 4'b0000, 0);
      tbl[36] = mkv(0, 0, 4'b0000, 4'b0000, 2'b00, 0, 0, 4'b0000, 0);

      repeat (2) @(posedge clk);

`ifndef WB_BYPASS_EN
      for (int r = 0; r < NROWS; r++) begin
         @(posedge clk);
         #1;
         applyStimulus(tbl[r], r);
         @(negedge clk);
         checkOutput(tbl[r], r);
         sbUpdate(tbl[r], r);
      end
      cmp("sb_drained", NROWS, 128'(sbq.size()), 128'(0));
`endif

      // Lone FU3 result after reset: latency 0 with bypass, latency 1 without.
      @(posedge clk);
      #1;
      rst         = 1'b1;
      sq_if.valid = 1'b0;
      fu_vld      = '0;
      repeat (2) @(posedge clk);
      #1;
      rst      = 1'b0;
      p.pc     = 32'h0000_4000;
      p.id     = 8'd3;
      p.prd    = 6'd7;
      p.rdval  = 32'h0000_1234;
      fu_in[3] = p;
      fu_vld   = 4'b1000;
      @(negedge clk);
      cmp("lone_reset_afull", 100, 128'(afull), 128'(4'b0000));
      cmp("lone_reset_ovf",   100, 128'(ovf),   128'(1'b0));
`ifdef WB_BYPASS_EN
      cmp("lone_same_valid", 100, 128'(wb_vld), 128'(2'b01));
      cmp("lone_same_data",  100, 128'(wb[0]),  128'(p));
`else
      cmp("lone_same_valid", 100, 128'(wb_vld), 128'(2'b00));
`endif
      @(posedge clk);
      #1;
      fu_vld = '0;
      @(negedge clk);
`ifdef WB_BYPASS_EN
      cmp("lone_next_valid", 101, 128'(wb_vld), 128'(2'b00));
`else
      cmp("lone_next_valid", 101, 128'(wb_vld), 128'(2'b01));
      cmp("lone_next_data",  101, 128'(wb[0]),  128'(p));
`endif
      @(posedge clk);
      #1;
      @(negedge clk);
      cmp("lone_drained", 102, 128'(wb_vld), 128'(2'b00));

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
